// File: rtl/l1_trig_event_stream_if.sv
// ---------------------------------------------------------------------------
// l1_trig_event_stream_if
//   AXI4-Stream carrier for the 128-bit trigger event words.
//   m_tdata  : packed event word (four reserved zero bits per 16-bit lane)
//   m_tvalid : head word available
//   m_tready : sink accepts the head word
//   master   : event source (drives data/valid)
//   slave    : event sink (drives ready)
// ---------------------------------------------------------------------------
interface l1_trig_event_stream_if;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;

  modport master (output m_tdata, output m_tvalid, input  m_tready);
  modport slave  (input  m_tdata, input  m_tvalid, output m_tready);
endinterface

// File: rtl/l1_trig_event_stream.sv
// ---------------------------------------------------------------------------
// l1_trig_event_stream
//   Per-beam L1 trigger conditioning: mask, holdoff dead-time, pulse
//   stretching, gated saturating rate scalers, and a timestamped event
//   stream through a small FIFO onto AXI4-Stream.
//
//   aclk           : clock, rising edge
//   aresetn        : asynchronous active-low reset, release synchronised
//   trig_i         : raw per-beam triggers
//   mask_i         : 1 = beam masked
//   holdoff_i      : dead-time loaded on every accept
//   stretch_o      : accepted triggers stretched to STRETCH cycles
//   scaler_o       : per-beam accept counts of the last gate period
//   scaler_valid_o : one-cycle strobe when scaler_o updates
//   m_axis         : event stream master (m_tdata/m_tvalid/m_tready)
//   overflow_o     : sticky, an event was dropped on a full FIFO
//   drop_count_o   : saturating count of dropped events
// ---------------------------------------------------------------------------
module l1_trig_event_stream #(
  parameter int unsigned NBEAMS       = 2,
  parameter int unsigned HOLDOFF_BITS = 8,
  parameter int unsigned STRETCH      = 4,
  parameter int unsigned SCALER_BITS  = 16,
  parameter int unsigned PERIOD       = 1024,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NBEAMS-1:0]             trig_i,
  input  logic [NBEAMS-1:0]             mask_i,
  input  logic [HOLDOFF_BITS-1:0]       holdoff_i,
  output logic [NBEAMS-1:0]             stretch_o,
  output logic [NBEAMS*SCALER_BITS-1:0] scaler_o,
  output logic                          scaler_valid_o,
  l1_trig_event_stream_if.master        m_axis,
  output logic                          overflow_o,
  output logic [15:0]                   drop_count_o
);

  localparam int unsigned STR_W  = $clog2(STRETCH + 1);
  localparam int unsigned GATE_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;

  // Reset: assertion is immediate, release is taken through two flops.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Accept, holdoff and stretch
  logic [NBEAMS-1:0]       w_acc;
  logic [HOLDOFF_BITS-1:0] r_holdoff [NBEAMS];
  logic [STR_W-1:0]        r_str     [NBEAMS];

  always_comb begin
    w_acc     = '0;
    stretch_o = '0;
    for (int unsigned b = 0; b < NBEAMS; b++) begin
      w_acc[b]     = trig_i[b] & ~mask_i[b] & (r_holdoff[b] == '0);
      stretch_o[b] = (r_str[b] != '0);
    end
  end

  // Mask only gates new accepts; running holdoff/stretch keep counting.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned b = 0; b < NBEAMS; b++) begin
        r_holdoff[b] <= '0;
        r_str[b]     <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NBEAMS; b++) begin
        if (w_acc[b])                r_holdoff[b] <= holdoff_i;
        else if (r_holdoff[b] != '0) r_holdoff[b] <= r_holdoff[b] - HOLDOFF_BITS'(1);

        if (w_acc[b])            r_str[b] <= STR_W'(STRETCH);
        else if (r_str[b] != '0) r_str[b] <= r_str[b] - STR_W'(1);
      end
    end
  end

  // Timestamp, sequence and event word staging
  logic [31:0] r_ts;
  logic [31:0] r_seq;
  logic        r_evt_valid;
  logic [95:0] r_evt_word;

  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ts        <= '0;
      r_seq       <= '0;
      r_evt_valid <= 1'b0;
      r_evt_word  <= '0;
    end else begin
      r_ts        <= r_ts + 32'd1;
      r_evt_valid <= |w_acc;
      if (|w_acc) begin
        r_seq      <= r_seq + 32'd1;
        r_evt_word <= {r_seq, 32'(w_acc), r_ts};
      end
    end
  end

  // Event FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [95:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_push;
  logic         w_drop;
  logic [95:0]  w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && m_axis.m_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = r_evt_valid && (!w_full || w_pop);
  assign w_drop  = r_evt_valid && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_evt_word;
  end

  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Output forced to zero when empty so the bus is clean in reset/idle.
  assign m_axis.m_tvalid = !w_empty;

  always_comb begin
    m_axis.m_tdata = '0;
    if (!w_empty) begin
      for (int unsigned i = 0; i < 8; i++) begin
        m_axis.m_tdata[16*i+4 +: 12] = w_head[12*i +: 12];
      end
    end
  end

  // Overflow / drop accounting
  logic        r_overflow;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign overflow_o   = r_overflow;
  assign drop_count_o = r_drop_cnt;

  // Gated rate scalers
  logic [GATE_W-1:0]             r_gate;
  logic                          w_gate_last;
  logic [SCALER_BITS-1:0]        r_cnt      [NBEAMS];
  logic [SCALER_BITS-1:0]        w_cnt_next [NBEAMS];
  logic [NBEAMS*SCALER_BITS-1:0] r_scaler;
  logic                          r_scaler_valid;

  assign w_gate_last = (r_gate == GATE_W'(PERIOD - 1));

  always_comb begin
    for (int unsigned b = 0; b < NBEAMS; b++) begin
      w_cnt_next[b] = r_cnt[b];
      if (w_acc[b] && (r_cnt[b] != '1)) w_cnt_next[b] = r_cnt[b] + SCALER_BITS'(1);
    end
  end

  // Counters clear at the end of the last gate cycle, so the first cycle
  // of the next gate starts from zero and its accept counts as one.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_gate         <= '0;
      r_scaler       <= '0;
      r_scaler_valid <= 1'b0;
      for (int unsigned b = 0; b < NBEAMS; b++) r_cnt[b] <= '0;
    end else begin
      r_scaler_valid <= w_gate_last;
      r_gate         <= w_gate_last ? '0 : r_gate + GATE_W'(1);
      for (int unsigned b = 0; b < NBEAMS; b++) begin
        if (w_gate_last) begin
          r_scaler[b*SCALER_BITS +: SCALER_BITS] <= w_cnt_next[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= w_cnt_next[b];
        end
      end
    end
  end

  assign scaler_o       = r_scaler;
  assign scaler_valid_o = r_scaler_valid;

endmodule

// File: doc/l1_trig_event_stream.md
L1_TRIG_EVENT_STREAM -- requirements
Module: l1_trig_event_stream

Interface
REQ-001 The block SHALL have parameter NBEAMS, default 2: beam trigger count, 1..32.
REQ-002 The block SHALL have parameter HOLDOFF_BITS, default 8: width of the per-beam holdoff count.
REQ-003 The block SHALL have parameter STRETCH, default 4: stretched-pulse length in cycles, >=1.
REQ-004 The block SHALL have parameter SCALER_BITS, default 16: width of each per-beam scaler.
REQ-005 The block SHALL have parameter PERIOD, default 1024: scaler gate length in cycles, >=2.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 16: event FIFO depth in words, a power of two.
REQ-007 The block SHALL have port aclk, input, 1: the single clock; all logic is on rising edge.
REQ-008 The block SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-009 The block SHALL have port trig_i, input, NBEAMS: raw per-beam trigger, one bit per beam.
REQ-010 The block SHALL have port mask_i, input, NBEAMS: 1 = beam masked.
REQ-011 The block SHALL have port holdoff_i, input, HOLDOFF_BITS: dead-time after an accept.
REQ-012 The block SHALL have port stretch_o, output, NBEAMS: stretched accepted triggers.
REQ-013 The block SHALL have port scaler_o, output, NBEAMS*SCALER_BITS: beam b is at [b*SCALER_BITS +: SCALER_BITS].
REQ-014 The block SHALL have port scaler_valid_o, output, 1: one-cycle strobe when scaler_o updates.
REQ-015 The block SHALL have ports m_tdata (output, 128), m_tvalid (output, 1) and m_tready (input, 1): AXI4-Stream event master.
REQ-016 The block SHALL have port overflow_o, output, 1: sticky flag set by an event dropped on full FIFO.
REQ-017 The block SHALL have port drop_count_o, output, 16: count of dropped events, saturating.

Function
REQ-018 An accept of beam b SHALL occur in a cycle where trig_i[b]=1, mask_i[b]=0 and holdoff[b]=0.
REQ-019 On accept, holdoff[b] SHALL load holdoff_i; otherwise it decrements while nonzero; holdoff_i=0 permits an accept every cycle.
REQ-020 On accept, stretch_o[b] SHALL go high the next cycle for exactly STRETCH cycles; a re-accept while high restarts the full count.
REQ-021 A free-running 32-bit timestamp SHALL increment every cycle and wrap 0xFFFFFFFF->0.
REQ-022 An event word SHALL be generated in any cycle with at least one accept: [31:0] = timestamp in the accept cycle, [63:32] = accept vector zero-extended, [95:64] = 32-bit sequence number.
REQ-023 The sequence number SHALL start at 0, increment per generated event including dropped events, and wrap.
REQ-024 Each 96-bit word SHALL be packed to m_tdata with 12-bit field i at m_tdata[16*i+4 +: 12] and m_tdata[16*i +: 4]=0, for i=0..7.
REQ-025 Words SHALL pass through a FIFO_DEPTH FIFO; m_tvalid=1 iff the FIFO is not empty; the word is consumed on m_tvalid&m_tready.
REQ-026 m_tdata SHALL be held stable while m_tvalid=1 and m_tready=0.
REQ-027 Latency from accept cycle to m_tvalid SHALL be 2 cycles when the FIFO is empty.
REQ-028 A simultaneous push and pop on a full FIFO SHALL accept the push, with no drop.
REQ-029 An event arriving when the FIFO is full with no pop SHALL be dropped: overflow_o set, drop_count_o incremented, saturating at 0xFFFF.
REQ-030 Each per-beam scaler SHALL count accepts, saturating at all-ones.
REQ-031 A PERIOD-cycle gate counter SHALL run continuously; in the last gate cycle, counts (including that cycle's accepts) SHALL be latched to scaler_o and scaler_valid_o pulsed the next cycle.
REQ-032 Counters SHALL restart at 0 in the first cycle of each new gate; an accept in that first cycle counts as 1.
REQ-033 Masking a beam SHALL NOT clear its holdoff or stretch state in progress.

Reset
REQ-034 While aresetn=0, all outputs SHALL be 0, the FIFO empty, and holdoff, stretch, timestamp, sequence, gate and scaler counters at 0.
REQ-035 Deassertion of aresetn SHALL be synchronised internally; the first gate period SHALL start on the first cycle after release, and any mid-stream reset discards FIFO contents.

Verification
REQ-036 Bench SHALL apply holdoff_i=3 with trig_i[0] held high for 12 cycles -> accepts in cycles 0,4,8; stretch_o[0] high for 12 cycles continuous.
REQ-037 Bench SHALL apply trig_i=2'b11 at timestamp 0x10 with m_tready=1 -> one word, fields ts=0x10, beams=0x3, seq=0, packed per REQ-024, m_tvalid 2 cycles later.
REQ-038 Bench SHALL apply m_tready=0 with 20 single accepts and FIFO_DEPTH=16 -> 16 words held, overflow_o=1, drop_count_o=4, and after drain seq values 0..15.
REQ-039 Bench SHALL run PERIOD=8 with beam 1 accepting every cycle and SCALER_BITS=2 -> scaler_o beam 1 = 3 (saturated), scaler_valid_o one pulse per 8 cycles.
REQ-040 Bench SHALL assert aresetn=0 mid-burst with a non-empty FIFO -> m_tvalid=0 immediately, all outputs 0, and the next event after release has seq=0.
